// File: rtl/rv32_pipe_pkg.sv
// Shared types for the fetch/decode pipeline buffer: the NOP encoding,
// the buffered entry layout and the occupancy states of the 2-entry skid FIFO.
package rv32_pipe_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    // addi x0, x0, 0
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc_plus1;
    } if_id_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Occupancy transition. Flush empties the buffer regardless of push/pop;
    // push and pop must already be qualified against the current state.
    function automatic occ_e occ_next(input occ_e cur, input logic push,
                                      input logic pop, input logic flush);
        occ_e nxt;
        nxt = cur;
        if (flush) begin
            nxt = OCC_EMPTY;
        end else begin
            case (cur)
                OCC_EMPTY: if (push) nxt = OCC_ONE;
                OCC_ONE: begin
                    if (push && !pop)      nxt = OCC_TWO;
                    else if (pop && !push) nxt = OCC_EMPTY;
                    else                   nxt = OCC_ONE;
                end
                OCC_TWO:   if (pop) nxt = OCC_ONE;
                default:   nxt = OCC_EMPTY;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/if_id_buffer_skid_buf2.sv
// skid_buf2: generic 2-entry FIFO with push/pop/flush. The head entry lives in
// its own register so the consumer sees registered data; the second slot only
// fills while the head is blocked.
module skid_buf2
    import rv32_pipe_pkg::*;
#(
    parameter int W = $bits(if_id_entry_t)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [1:0]   o_count,
    output logic         o_valid,
    output logic [W-1:0] o_head
);

    occ_e         r_state;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         w_push;
    logic         w_pop;

    // A push into a full buffer or a pop from an empty one is ignored.
    assign w_push = i_push && (r_state != OCC_TWO);
    assign w_pop  = i_pop  && (r_state != OCC_EMPTY);

    // Occupancy state; reset wins over flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= occ_next(r_state, w_push, w_pop, i_flush);
        end
    end

    // Head register: loaded directly when the incoming entry becomes the head,
    // or from the tail slot when the head is popped with two entries held.
    // Flush leaves the data untouched so the PC outputs keep their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
        end else if (!i_flush) begin
            if (w_push && ((r_state == OCC_EMPTY) || ((r_state == OCC_ONE) && w_pop))) begin
                r_head <= i_data;
            end else if (w_pop && (r_state == OCC_TWO)) begin
                r_head <= r_tail;
            end
        end
    end

    // Tail slot captures a push only while the head is held.
    always_ff @(posedge clk) begin
        if (!i_flush && w_push && (r_state == OCC_ONE) && !w_pop) begin
            r_tail <= i_data;
        end
    end

    assign o_count = r_state;
    assign o_valid = (r_state != OCC_EMPTY);
    assign o_head  = r_head;

endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode pipeline buffer built on skid_buf2.
// Computes the instruction PC (pc_plus1 - 1, modulo 2^AddrSize) at push time,
// substitutes NOP_INST while no entry is valid, and keeps if_ready purely a
// function of registered occupancy.
// Optional build macro IFID_PERF_CNT_EN adds saturating bubble/stall counters.
module if_id_buffer
    import rv32_pipe_pkg::*;
#(
    parameter int AddrSize  = 32,
    parameter int Inst_Size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_valid,
    input  logic [Inst_Size-1:0] if_inst,
    input  logic [AddrSize-1:0]  if_pc_plus1,
    output logic                 if_ready,
    input  logic                 flush,
    input  logic                 id_ready,
    output logic                 id_valid,
    output logic [Inst_Size-1:0] id_inst,
    output logic [AddrSize-1:0]  id_pc,
    output logic [AddrSize-1:0]  id_pc_plus1
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]          bubble_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    typedef struct packed {
        logic [Inst_Size-1:0] inst;
        logic [AddrSize-1:0]  pc;
        logic [AddrSize-1:0]  pc_plus1;
    } entry_t;

    localparam int EntryW = $bits(entry_t);
    localparam logic [Inst_Size-1:0] NopInst = Inst_Size'(NOP_INST);

    entry_t             w_push_entry;
    entry_t             w_head_entry;
    logic [EntryW-1:0]  w_head_bits;
    logic [1:0]         w_count;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;

    assign w_push = if_valid && if_ready;
    assign w_pop  = w_valid && id_ready;

    assign w_push_entry.inst     = if_inst;
    assign w_push_entry.pc       = if_pc_plus1 - AddrSize'(1);
    assign w_push_entry.pc_plus1 = if_pc_plus1;

    skid_buf2 #(
        .W (EntryW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_data  (w_push_entry),
        .o_count (w_count),
        .o_valid (w_valid),
        .o_head  (w_head_bits)
    );

    assign w_head_entry = entry_t'(w_head_bits);

    // Ready depends only on the registered count, never on id_ready.
    assign if_ready    = (w_count != 2'd2);
    assign id_valid    = w_valid;
    assign id_inst     = w_valid ? w_head_entry.inst : NopInst;
    assign id_pc       = w_head_entry.pc;
    assign id_pc_plus1 = w_head_entry.pc_plus1;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_stall_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Performance counters; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (!w_valid) begin
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end
            if (if_valid && !if_ready) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Testbench for if_id_buffer: directed vector table, a few hand sequences and
// randomized traffic against a queue-based reference model.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = '0;
    logic [31:0] if_pc_plus1 = '0;
    logic        if_ready;
    logic        flush = 1'b0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus1;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    if_id_buffer #(.AddrSize(32), .Inst_Size(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc_plus1 (if_pc_plus1),
        .if_ready    (if_ready),
        .flush       (flush),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc_plus1 (id_pc_plus1)
`ifdef IFID_PERF_CNT_EN
        ,
        .bubble_cnt  (bubble_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pcp1;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc   = '0;
    logic [31:0] m_pcp1 = '0;
    logic [31:0] m_bub  = '0;
    logic [31:0] m_stl  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic        ev;
        logic [31:0] ei;
        ev = (mq.size() != 0);
        ei = ev ? mq[0].inst : NOP;
        chk("mdl_id_valid",    32'(id_valid), 32'(ev));
        chk("mdl_id_inst",     id_inst, ei);
        chk("mdl_id_pc",       id_pc, m_pc);
        chk("mdl_id_pc_plus1", id_pc_plus1, m_pcp1);
        chk("mdl_if_ready",    32'(if_ready), 32'(mq.size() != 2));
`ifdef IFID_PERF_CNT_EN
        chk("mdl_bubble_cnt",  bubble_cnt, m_bub);
        chk("mdl_stall_cnt",   stall_cnt, m_stl);
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic apply(input logic rst, input logic v, input logic [31:0] inst,
                         input logic [31:0] pcp1, input logic fl, input logic rdy);
        bit pre_valid;
        bit pre_ready;
        reset       = rst;
        if_valid    = v;
        if_inst     = inst;
        if_pc_plus1 = pcp1;
        flush       = fl;
        id_ready    = rdy;
        pre_valid   = (mq.size() != 0);
        pre_ready   = (mq.size() < 2);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_pc   = '0;
            m_pcp1 = '0;
            m_bub  = '0;
            m_stl  = '0;
        end else begin
            if (!pre_valid && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
            if (v && !pre_ready && m_stl != 32'hFFFF_FFFF) m_stl = m_stl + 1;
            if (fl) begin
                mq.delete();
            end else begin
                if (pre_valid && rdy) void'(mq.pop_front());
                if (v && pre_ready) mq.push_back('{inst, pcp1 - 32'd1, pcp1});
            end
            if (mq.size() != 0) begin
                m_pc   = mq[0].pc;
                m_pcp1 = mq[0].pcp1;
            end
        end
        #1;
        check_model();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] inst;
        logic [31:0] pcp1;
        logic        fl;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_pcp1;
        logic        e_ready;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rst, input logic v, input logic [31:0] inst,
                       input logic [31:0] pcp1, input logic fl, input logic rdy,
                       input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                       input logic [31:0] ep1, input logic er);
        tv.push_back('{rst, v, inst, pcp1, fl, rdy, ev, ei, ep, ep1, er});
    endtask

    initial begin
        // Reset held 3 cycles with if_valid high: nothing captured.
        add(1, 1, 32'hDEAD_0001, 32'h9, 0, 0,   0, NOP, 32'h0, 32'h0, 1);
        add(1, 1, 32'hDEAD_0001, 32'h9, 0, 0,   0, NOP, 32'h0, 32'h0, 1);
        add(1, 1, 32'hDEAD_0001, 32'h9, 0, 0,   0, NOP, 32'h0, 32'h0, 1);
        add(0, 0, 32'hDEAD_0001, 32'h9, 0, 0,   0, NOP, 32'h0, 32'h0, 1);
        // Streaming A..D with pc_plus1 5..8.
        add(0, 1, 32'h0000_000A, 32'h5, 0, 1,   1, 32'hA, 32'h4, 32'h5, 1);
        add(0, 1, 32'h0000_000B, 32'h6, 0, 1,   1, 32'hB, 32'h5, 32'h6, 1);
        add(0, 1, 32'h0000_000C, 32'h7, 0, 1,   1, 32'hC, 32'h6, 32'h7, 1);
        add(0, 1, 32'h0000_000D, 32'h8, 0, 1,   1, 32'hD, 32'h7, 32'h8, 1);
        add(0, 0, 32'h0,         32'h0, 0, 1,   0, NOP,   32'h7, 32'h8, 1);
        // Backpressure: A, B accepted, C refused, then drained in order.
        add(0, 1, 32'h0000_00A1, 32'h10, 0, 0,  1, 32'hA1, 32'hF,  32'h10, 1);
        add(0, 1, 32'h0000_00B1, 32'h11, 0, 0,  1, 32'hA1, 32'hF,  32'h10, 0);
        add(0, 1, 32'h0000_00C1, 32'h12, 0, 0,  1, 32'hA1, 32'hF,  32'h10, 0);
        add(0, 1, 32'h0000_00C1, 32'h12, 0, 1,  1, 32'hB1, 32'h10, 32'h11, 1);
        add(0, 1, 32'h0000_00C1, 32'h12, 0, 1,  1, 32'hC1, 32'h11, 32'h12, 1);
        add(0, 0, 32'h0,         32'h0,  0, 1,  0, NOP,    32'h11, 32'h12, 1);
        // Flush at TWO with concurrent push and id_ready.
        add(0, 1, 32'h0000_00E1, 32'h20, 0, 0,  1, 32'hE1, 32'h1F, 32'h20, 1);
        add(0, 1, 32'h0000_00F1, 32'h21, 0, 0,  1, 32'hE1, 32'h1F, 32'h20, 0);
        add(0, 1, 32'h0000_0061, 32'h22, 1, 1,  0, NOP,    32'h1F, 32'h20, 1);
        add(0, 0, 32'h0,         32'h0,  0, 1,  0, NOP,    32'h1F, 32'h20, 1);
        // Simultaneous push/pop at ONE, with pc_plus1 wrap.
        add(0, 1, 32'h0000_0071, 32'h30, 0, 0,  1, 32'h71, 32'h2F, 32'h30, 1);
        add(0, 1, 32'h0000_0081, 32'h0,  0, 1,  1, 32'h81, 32'hFFFF_FFFF, 32'h0, 1);
        add(0, 0, 32'h0,         32'h0,  0, 1,  0, NOP,    32'hFFFF_FFFF, 32'h0, 1);
        // Mid-operation reset overrides a concurrent flush and push.
        add(0, 1, 32'h0000_0091, 32'h40, 0, 0,  1, 32'h91, 32'h3F, 32'h40, 1);
        add(1, 1, 32'h0000_00A2, 32'h41, 1, 0,  0, NOP,    32'h0,  32'h0,  1);

        foreach (tv[i]) begin
            apply(tv[i].rst, tv[i].v, tv[i].inst, tv[i].pcp1, tv[i].fl, tv[i].rdy);
            chk($sformatf("tv%0d_id_valid", i),    32'(id_valid), 32'(tv[i].e_valid));
            chk($sformatf("tv%0d_id_inst", i),     id_inst, tv[i].e_inst);
            chk($sformatf("tv%0d_id_pc", i),       id_pc, tv[i].e_pc);
            chk($sformatf("tv%0d_id_pc_plus1", i), id_pc_plus1, tv[i].e_pcp1);
            chk($sformatf("tv%0d_if_ready", i),    32'(if_ready), 32'(tv[i].e_ready));
        end

        // Holding: entry stays stable while decode is stalled for several cycles.
        apply(0, 1, 32'h0000_1234, 32'h100, 0, 0);
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 32'h0, 32'h0, 0, 0);
            chk("hold_id_inst", id_inst, 32'h0000_1234);
            chk("hold_id_pc",   id_pc,   32'h0000_00FF);
        end
        apply(0, 0, 32'h0, 32'h0, 0, 1);
        chk("hold_drain_valid", 32'(id_valid), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst;
            logic        r_fl;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 199) == 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            r_pc  = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
            apply(r_rst, ($urandom_range(0, 3) != 0), $urandom, r_pc, r_fl,
                  ($urandom_range(0, 2) != 0));
        end

`ifdef IFID_PERF_CNT_EN
        // Counters: idle bubbles, fill, stalled pushes, then a flush.
        apply(1, 0, 32'h0, 32'h0, 0, 0);
        for (int k = 0; k < 5; k++) apply(0, 0, 32'h0, 32'h0, 0, 0);
        chk("perf_bubble_idle", bubble_cnt, 32'd5);
        chk("perf_stall_idle",  stall_cnt,  32'd0);
        apply(0, 1, 32'h111, 32'h51, 0, 0);
        apply(0, 1, 32'h222, 32'h52, 0, 0);
        apply(0, 1, 32'h333, 32'h53, 0, 0);
        apply(0, 1, 32'h333, 32'h53, 0, 0);
        chk("perf_bubble_fill", bubble_cnt, 32'd6);
        chk("perf_stall_fill",  stall_cnt,  32'd2);
        apply(0, 0, 32'h0, 32'h0, 1, 0);
        chk("perf_bubble_flush", bubble_cnt, 32'd6);
        chk("perf_stall_flush",  stall_cnt,  32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound, got running expected finished");
        $fatal(1);
    end

endmodule
